leb128_decoder: RTL and testbench

//  Streaming LEB128 immediate decoder for the CPU fetch path. It decodes the operands of
//  i32.const/i64.const and the signed/unsigned varint operands of other instructions.

---
 rtl/leb128_decoder.sv | 73 +++++++
 tb/tb_leb128_decoder.sv | 136 +++++++++++++
 2 files changed

// File: rtl/leb128_decoder.sv
// leb128_decoder: streaming signed/unsigned LEB128 immediate decoder with trap reporting
module leb128_decoder #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [7:0]       in_byte,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       bytes_used,
  output logic             done,
  output logic             busy,
  output logic [2:0]       trap
);
  localparam int MAX_BYTES = (WIDTH + 6) / 7;
  localparam int U = WIDTH - 7 * (MAX_BYTES - 1);
  localparam logic [1:0] IDLE = 2'd0, DECODE = 2'd1, DONE = 2'd2;
  logic [1:0] state;
  logic [WIDTH-1:0] acc, acc_nx;
  logic [6:0] shift, shift_nx;
  logic [3:0] count;
  logic sgn, take, last_slot, final_byte, overlong, pad_bad, ext;
  assign in_ready = state == DECODE;
  assign done = state == DONE;
  assign busy = state != IDLE;
  // next accumulator value, byte classification and final-byte checks
  always_comb begin
    take = state == DECODE && in_valid && !start;
    last_slot = count == 4'(MAX_BYTES - 1);
    final_byte = !in_byte[7] || last_slot;
    overlong = in_byte[7] && last_slot;
    shift_nx = shift + 7'd7;
    acc_nx = acc | (WIDTH'(in_byte[6:0]) << shift);
    pad_bad = last_slot && !in_byte[7] &&
              (sgn ? in_byte[6:U] != {(7-U){in_byte[U-1]}} : in_byte[6:U] != '0);
    ext = sgn && in_byte[6] && !overlong && shift_nx < 7'(WIDTH);
  end
  // FSM, accumulation and result/trap capture one cycle after the final byte
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      acc <= '0;
      shift <= '0;
      count <= '0;
      sgn <= 1'b0;
      result <= '0;
      bytes_used <= '0;
      trap <= '0;
    end else if (start) begin
      state <= DECODE;
      acc <= '0;
      shift <= '0;
      count <= '0;
      trap <= '0;
      sgn <= is_signed;
    end else if (take) begin
      acc <= acc_nx;
      shift <= shift_nx;
      count <= count + 4'd1;
      if (final_byte) begin
        state <= DONE;
        result <= ext ? acc_nx | ({WIDTH{1'b1}} << shift_nx) : acc_nx;
        bytes_used <= count + 4'd1;
        trap <= overlong ? 3'd1 : pad_bad ? 3'd2 : 3'd0;
      end
    end else if (state == DONE) begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_leb128_decoder.sv
// tb_leb128_decoder: directed checks of the LEB128 decoder at WIDTH=64 and WIDTH=32
module tb_leb128_decoder;
  logic clk = 0, reset = 1, start64 = 0, start32 = 0, is_signed = 0, in_valid = 0;
  logic [7:0] in_byte = 0;
  logic in_ready64, done64, busy64, in_ready32, done32, busy32;
  logic [63:0] result64;
  logic [31:0] result32;
  logic [3:0] bu64, bu32;
  logic [2:0] trap64, trap32;
  int tests = 0, fails = 0, ndone = 0;
  logic [7:0] bq[$];

  leb128_decoder #(.WIDTH(64)) dut64 (
    .clk(clk), .reset(reset), .start(start64), .is_signed(is_signed), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready64), .result(result64), .bytes_used(bu64),
    .done(done64), .busy(busy64), .trap(trap64));
  leb128_decoder #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .start(start32), .is_signed(is_signed), .in_byte(in_byte),
    .in_valid(in_valid), .in_ready(in_ready32), .result(result32), .bytes_used(bu32),
    .done(done32), .busy(busy32), .trap(trap32));

  always #5 clk = ~clk;
  always @(negedge clk) if (done64 || done32) ndone++;

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask

  task automatic run(input bit w32, input bit sg, input int gap, input logic [63:0] er,
                     input logic [3:0] en, input logic [2:0] et, input string tag);
    int n0;
    n0 = ndone;
    @(negedge clk);
    is_signed = sg;
    if (w32) start32 = 1; else start64 = 1;
    @(negedge clk);
    start32 = 0;
    start64 = 0;
    for (int i = 0; i < bq.size(); i++) begin
      if (i > 0 && gap > 0) begin
        in_valid = 0;
        repeat (gap) @(negedge clk);
      end
      in_valid = 1;
      in_byte = bq[i];
      if (i == bq.size() - 1) chk({tag, " done_early"}, {63'd0, w32 ? done32 : done64}, 0);
      @(posedge clk);
      #1;
      @(negedge clk);
      if (i == bq.size() - 1) begin
        in_valid = 0;
        chk({tag, " done"}, {63'd0, w32 ? done32 : done64}, 1);
        chk({tag, " result"}, w32 ? {32'd0, result32} : result64, er);
        chk({tag, " bytes_used"}, {60'd0, w32 ? bu32 : bu64}, {60'd0, en});
        chk({tag, " trap"}, {61'd0, w32 ? trap32 : trap64}, {61'd0, et});
      end else begin
        in_valid = 0;
      end
    end
    repeat (3) @(negedge clk);
    chk({tag, " done_pulses"}, 64'(ndone - n0), 1);
  endtask

  initial begin
    #1;
    chk("rst result", result64, 0);
    chk("rst bytes_used", {60'd0, bu64}, 0);
    chk("rst flags", {59'd0, done64, busy64, in_ready64, trap64 != 0}, 0);
    @(negedge clk);
    reset = 0;
    bq = '{8'h2A};
    run(0, 0, 0, 64'd42, 4'd1, 3'd0, "u42");
    bq = '{8'h7F};
    run(0, 1, 0, 64'hFFFF_FFFF_FFFF_FFFF, 4'd1, 3'd0, "s_m1");
    bq = '{8'hC0, 8'hBB, 8'h78};
    run(0, 1, 0, 64'hFFFF_FFFF_FFFE_1DC0, 4'd3, 3'd0, "s_m123456");
    bq = '{8'hE5, 8'h8E, 8'h26};
    run(0, 0, 2, 64'd624485, 4'd3, 3'd0, "u624485_gaps");
    bq = {};
    repeat (9) bq.push_back(8'h80);
    bq.push_back(8'h7F);
    run(0, 1, 0, 64'h8000_0000_0000_0000, 4'd10, 3'd0, "s_min64");
    bq[9] = 8'h02;
    run(0, 1, 0, 64'd0, 4'd10, 3'd2, "s_pad64");
    bq[9] = 8'h80;
    run(0, 1, 0, 64'd0, 4'd10, 3'd1, "overlong64");
    bq = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h0F};
    run(1, 0, 0, 64'hFFFF_FFFF, 4'd5, 3'd0, "u_max32");
    bq[4] = 8'h1F;
    run(1, 0, 0, 64'hFFFF_FFFF, 4'd5, 3'd2, "u_pad32");
    @(negedge clk);
    is_signed = 0;
    start64 = 1;
    @(negedge clk);
    start64 = 0;
    in_valid = 1;
    in_byte = 8'hE5;
    @(negedge clk);
    in_byte = 8'h8E;
    @(negedge clk);
    in_valid = 0;
    chk("mid busy", {63'd0, busy64}, 1);
    reset = 1;
    #1;
    chk("mid_rst result", result64, 0);
    chk("mid_rst bytes_used", {60'd0, bu64}, 0);
    chk("mid_rst flags", {59'd0, done64, busy64, in_ready64, trap64 != 0}, 0);
    @(negedge clk);
    reset = 0;
    bq = '{8'h2A};
    run(0, 0, 0, 64'd42, 4'd1, 3'd0, "after_rst");
    @(negedge clk);
    start64 = 1;
    @(negedge clk);
    start64 = 0;
    in_valid = 1;
    in_byte = 8'hFF;
    @(negedge clk);
    start64 = 1;
    @(negedge clk);
    start64 = 0;
    in_byte = 8'h01;
    @(negedge clk);
    in_valid = 0;
    chk("restart done", {63'd0, done64}, 1);
    chk("restart result", result64, 64'd1);
    chk("restart bytes_used", {60'd0, bu64}, 1);
    repeat (2) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
